// File: rtl/cuckoo_pkg.sv
// rtl/cuckoo_pkg.sv - cuckoo table widths, FSM states and the hash/rebuild helpers shared with the banks
package cuckoo_pkg;

  localparam int TAG_W   = 12;
  localparam int INDEX_W = 6;
  localparam int KEY_W   = TAG_W + INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    KICK_R,
    KICK_L,
    RESP
  } state_e;

  function automatic logic [TAG_W-1:0] key_tag(input logic [KEY_W-1:0] k);
    return k[KEY_W-1:INDEX_W];
  endfunction

  // Low index bits of (k ^ k >> INDEX_W) and (k ^ k >> 2*INDEX_W).
  function automatic logic [INDEX_W-1:0] idx_left(input logic [KEY_W-1:0] k);
    return k[INDEX_W-1:0] ^ k[2*INDEX_W-1:INDEX_W];
  endfunction

  function automatic logic [INDEX_W-1:0] idx_right(input logic [KEY_W-1:0] k);
    return k[INDEX_W-1:0] ^ k[3*INDEX_W-1:2*INDEX_W];
  endfunction

  function automatic logic [KEY_W-1:0] rebuild_left(input logic [TAG_W-1:0] t,
                                                    input logic [INDEX_W-1:0] idx);
    return {t, idx ^ t[INDEX_W-1:0]};
  endfunction

  function automatic logic [KEY_W-1:0] rebuild_right(input logic [TAG_W-1:0] t,
                                                     input logic [INDEX_W-1:0] idx);
    return {t, idx ^ t[2*INDEX_W-1:INDEX_W]};
  endfunction

endpackage

// File: rtl/cuckoo_ctrl.sv
// rtl/cuckoo_ctrl.sv - 2-way cuckoo table controller: probes both banks, relocates victims up to MAX_KICKS
module cuckoo_ctrl
  import cuckoo_pkg::*;
#(
  parameter int TAG_WIDTH   = TAG_W,
  parameter int INDEX_WIDTH = INDEX_W,
  parameter int KEY_WIDTH   = TAG_WIDTH + INDEX_WIDTH,
  parameter int MAX_KICKS   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_op_i,
  input  logic [KEY_WIDTH-1:0] req_key_i,
  output logic                 resp_valid_o,
  output logic                 resp_hit_o,
  output logic                 resp_fail_o,
  output logic [KEY_WIDTH-1:0] resp_key_o,
  output logic                 bl_read_o,
  output logic                 br_read_o,
  output logic                 bl_write_o,
  output logic                 br_write_o,
  output logic [KEY_WIDTH-1:0] bl_data_o,
  output logic [KEY_WIDTH-1:0] br_data_o,
  input  logic [TAG_WIDTH-1:0] bl_tag_i,
  input  logic [TAG_WIDTH-1:0] br_tag_i
);

  localparam int KICK_W = (MAX_KICKS > 0) ? $clog2(MAX_KICKS + 1) : 1;

  state_e                 state, state_n;
  logic [KEY_WIDTH-1:0]   carry, carry_n, key_q, key_n;
  logic                   is_insert, op_n, hit_q, hit_n, fail_q, fail_n;
  logic [KICK_W-1:0]      kicks, kicks_n;

  logic [TAG_WIDTH-1:0]   carry_tag;
  logic [INDEX_WIDTH-1:0] carry_il, carry_ir;
  logic                   legal, hit, kicks_done;

  assign carry_tag  = key_tag(carry);
  assign carry_il   = idx_left(carry);
  assign carry_ir   = idx_right(carry);
  assign legal      = (carry_tag != '0);
  assign hit        = (bl_tag_i == carry_tag) || (br_tag_i == carry_tag);
  assign kicks_done = (kicks == KICK_W'(MAX_KICKS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      carry     <= '0;
      key_q     <= '0;
      is_insert <= 1'b0;
      kicks     <= '0;
      hit_q     <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state     <= state_n;
      carry     <= carry_n;
      key_q     <= key_n;
      is_insert <= op_n;
      kicks     <= kicks_n;
      hit_q     <= hit_n;
      fail_q    <= fail_n;
    end
  end

  always_comb begin
    state_n    = state;
    carry_n    = carry;
    key_n      = key_q;
    op_n       = is_insert;
    kicks_n    = kicks;
    hit_n      = hit_q;
    fail_n     = fail_q;
    bl_read_o  = 1'b0;
    br_read_o  = 1'b0;
    bl_write_o = 1'b0;
    br_write_o = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          op_n    = req_op_i;
          key_n   = req_key_i;
          carry_n = req_key_i;
          kicks_n = '0;
          hit_n   = 1'b0;
          fail_n  = 1'b0;
          state_n = PROBE;
        end
      end
      PROBE: begin
        state_n = RESP;
        if (!legal) begin
          fail_n = 1'b1;
        end else begin
          bl_read_o = 1'b1;
          br_read_o = 1'b1;
          hit_n     = hit;
          if (hit || !is_insert) begin
            hit_n = hit;
          end else if (bl_tag_i == '0) begin
            bl_write_o = 1'b1;
          end else if (br_tag_i == '0) begin
            br_write_o = 1'b1;
          end else if (kicks_done) begin
            fail_n = 1'b1;
          end else begin
            // Take the left slot and carry its resident over to the right bank.
            bl_write_o = 1'b1;
            carry_n    = rebuild_left(bl_tag_i, carry_il);
            kicks_n    = kicks + KICK_W'(1);
            state_n    = KICK_R;
          end
        end
      end
      KICK_R: begin
        br_read_o = 1'b1;
        state_n   = RESP;
        if (br_tag_i == '0) begin
          br_write_o = 1'b1;
        end else if (kicks_done) begin
          fail_n = 1'b1;
        end else begin
          br_write_o = 1'b1;
          carry_n    = rebuild_right(br_tag_i, carry_ir);
          kicks_n    = kicks + KICK_W'(1);
          state_n    = KICK_L;
        end
      end
      KICK_L: begin
        bl_read_o = 1'b1;
        state_n   = RESP;
        if (bl_tag_i == '0) begin
          bl_write_o = 1'b1;
        end else if (kicks_done) begin
          fail_n = 1'b1;
        end else begin
          bl_write_o = 1'b1;
          carry_n    = rebuild_left(bl_tag_i, carry_il);
          kicks_n    = kicks + KICK_W'(1);
          state_n    = KICK_R;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_ready_o  = (state == IDLE);
  assign resp_valid_o = (state == RESP);
  assign resp_hit_o   = (state == RESP) && hit_q;
  assign resp_fail_o  = (state == RESP) && fail_q;
  // On failure carry holds whichever key was left without a slot.
  assign resp_key_o   = (state != RESP) ? '0 : (fail_q ? carry : key_q);
  assign bl_data_o    = (bl_read_o || bl_write_o) ? carry : '0;
  assign br_data_o    = (br_read_o || br_write_o) ? carry : '0;

endmodule
